gauss_interp: RTL and testbench
===============================

GAUSS_INTERP -- requirements
Module: gauss_interp

Interface
REQ-001 SHALL have port clk, input, 1 bit: 10.24MHz system clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cpu_en, input, 1 bit: 1.024MHz clock enable; all state advances only on clk edges with cpu_en=1 ("tick").
REQ-004 SHALL have port start, input, 1 bit: request to interpolate, sampled on a tick.
REQ-005 SHALL have port pcm_x[3:0], input, 4x15 bits, signed: four consecutive decoded samples, oldest first (x0..x3).
REQ-006 SHALL have port index, input, 8 bits: fractional pitch position.
REQ-007 SHALL have port rom_addr, output, 9 bits: Gaussian table address.
REQ-008 SHALL have port rom_data, input, 11 bits, unsigned: table word, valid on the tick after its rom_addr.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port out_valid, output, 1 bit: out updated this tick period.
REQ-011 SHALL have port out, output, 15 bits, signed: interpolated sample.

Function
REQ-012 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, with term counter k (0..4) used in RUN.
REQ-013 On a tick in IDLE with start=1, SHALL latch pcm_x and index, clear the accumulator, set k=0, and enter RUN.
REQ-014 In RUN, rom_addr SHALL be, for k = 0, 1, 2, 3 respectively: 255-i, 511-i, 256+i, i, where i is the latched index; for k=4 it SHALL be don't-care.
REQ-015 On each RUN tick with k>=1, SHALL add term(k-1) = (x[k-1] * rom_data) arithmetically shifted right by 11 (floor) into a 17-bit signed accumulator, then increment k.
REQ-016 Each product SHALL be a full 26-bit signed product of a 15-bit signed sample and an 11-bit unsigned table word, with no intermediate truncation.
REQ-017 On the RUN tick with k=4, SHALL accumulate term3 and enter DONE.
REQ-018 On the DONE tick, SHALL saturate the accumulator to [-16384, 16383], register the result into out, set out_valid=1, and return to IDLE.
REQ-019 out_valid SHALL clear on the next tick, giving exactly one tick period high; out SHALL hold its value until the next DONE.
REQ-020 Latency SHALL be 6 ticks from the start tick to the out_valid rising edge.
REQ-021 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored when not in IDLE, with no queuing.
REQ-023 Changes to pcm_x and index after the start tick SHALL NOT affect the result in flight.
REQ-024 clk edges without cpu_en SHALL change no state and no output.

Reset
REQ-025 While reset=0, state SHALL be IDLE; k, the accumulator, and the latched inputs SHALL be 0; out=0, out_valid=0, busy=0, rom_addr=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation immediately, with no out_valid pulse.
REQ-027 The first start after reset release SHALL behave as a normal start.

Configuration
REQ-028 Macro GAUSS_WRAP_EN SHALL control term-2 wraparound.
REQ-029 With GAUSS_WRAP_EN defined, after term2 is accumulated the accumulator SHALL be truncated to its low 15 bits and sign-extended, emulating the hardware wrap, before term3 is added.
REQ-030 Without GAUSS_WRAP_EN, no wrap SHALL occur; only the final saturation of REQ-018 applies.

Verification
REQ-031 SHALL verify address order: index=0x10 -> rom_addr 239, 495, 272, 16 on consecutive RUN ticks.
REQ-032 SHALL verify the basic sum: stub ROM=1024, x={100,200,300,400} -> out=500, out_valid on tick 6.
REQ-033 SHALL verify floor rounding: stub ROM=1024, x={-1,0,0,0} -> out=-1.
REQ-034 SHALL verify wrap: stub ROM=2047, x={16383,16383,0,0} -> out=-18 with GAUSS_WRAP_EN, 16383 without.
REQ-035 SHALL verify that start is ignored while busy: start re-pulsed at tick 3 -> single out_valid at tick 6 with the first operation's result, and busy=0 at tick 7.
REQ-036 SHALL verify reset mid-operation: reset asserted at tick 4 -> out=0 and no out_valid; a new start after release -> correct result 6 ticks later.

Source files
------------

// File: rtl/gauss_interp.sv
// gauss_interp: four-tap Gaussian interpolator working one table term per tick.
//
// A start in IDLE captures four consecutive samples (oldest first) and the
// 8-bit fractional pitch index. RUN walks the four Gaussian table addresses in
// order, accumulating floor((x[k] * g) / 2048) into a 17-bit signed
// accumulator one tick behind the address, because the table answers a tick
// later. DONE saturates the sum to 15 bits and pulses out_valid for one tick.
// All state advances only on clk edges where cpu_en is high.
//
// Optional feature: define GAUSS_WRAP_EN to fold the accumulator to 15 bits
// (sign-extended) after the third term, reproducing the original hardware wrap.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   cpu_en    tick enable
//   start     request interpolation (sampled on a tick in IDLE)
//   pcm_x     four signed samples x0..x3
//   index     fractional pitch position
//   rom_addr  Gaussian table address
//   rom_data  table word, valid the tick after its address
//   busy      high in RUN and DONE
//   out_valid one-tick pulse when out is updated
//   out       saturated interpolated sample
`timescale 1ns/1ps

module gauss_interp #(
  parameter int DATA_W = 15,
  parameter int COEF_W = 11,
  parameter int STAGES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_en,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] pcm_x [STAGES],
  input  logic [7:0]               index,
  output logic [8:0]               rom_addr,
  input  logic [COEF_W-1:0]        rom_data,
  output logic                     busy,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out
);

  localparam int ACC_W  = DATA_W + 2;
  localparam int PROD_W = DATA_W + COEF_W + 1;

  localparam logic [2:0] K_LAST = 3'(STAGES);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (DATA_W - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x_p0 [STAGES];
  logic [7:0]               idx_p0;
  logic [2:0]               k_p1;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [DATA_W-1:0] out_p2;
  logic                     vld_p2;

  logic [1:0]               sel;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] c_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_nxt;

  // Arithmetic shift gives floor division by 2^COEF_W for negative products.
  function automatic logic signed [ACC_W-1:0] floor_scale(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p >>> COEF_W);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI) return DATA_W'(SAT_HI);
    if (a < SAT_LO) return DATA_W'(SAT_LO);
    return DATA_W'(a);
  endfunction

`ifdef GAUSS_WRAP_EN
  // Keep the low DATA_W bits and sign-extend them back to accumulator width.
  function automatic logic signed [ACC_W-1:0] wrap_acc(input logic signed [ACC_W-1:0] a);
    return ACC_W'(DATA_W'(a));
  endfunction
`endif

  // Term datapath: the word on rom_data belongs to the address issued for k-1.
  always_comb begin
    sel     = 2'(k_p1 - 3'd1);
    x_ext   = PROD_W'(x_p0[sel]);
    c_ext   = PROD_W'($signed({1'b0, rom_data}));
    prod    = x_ext * c_ext;
    term    = floor_scale(prod);
    acc_sum = acc_p1 + term;
`ifdef GAUSS_WRAP_EN
    acc_nxt = (k_p1 == 3'd3) ? wrap_acc(acc_sum) : acc_sum;
`else
    acc_nxt = acc_sum;
`endif
  end

  always_comb begin
    state_nxt = state;
    rom_addr  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        case (k_p1)
          3'd0:    rom_addr = 9'd255 - {1'b0, idx_p0};
          3'd1:    rom_addr = 9'd511 - {1'b0, idx_p0};
          3'd2:    rom_addr = 9'd256 + {1'b0, idx_p0};
          3'd3:    rom_addr = {1'b0, idx_p0};
          default: rom_addr = '0;
        endcase
        if (k_p1 == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (cpu_en) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < STAGES; j++) x_p0[j] <= '0;
      idx_p0 <= '0;
      k_p1   <= '0;
      acc_p1 <= '0;
      out_p2 <= '0;
      vld_p2 <= 1'b0;
    end else if (cpu_en) begin
      vld_p2 <= 1'b0;
      case (state)
        // ---- stage p0: capture operands ----
        IDLE: begin
          if (start) begin
            x_p0   <= pcm_x;
            idx_p0 <= index;
            k_p1   <= '0;
            acc_p1 <= '0;
          end
        end
        // ---- stage p1: accumulate one term per tick ----
        RUN: begin
          if (k_p1 != 3'd0) acc_p1 <= acc_nxt;
          k_p1 <= k_p1 + 3'd1;
        end
        // ---- stage p2: saturate and publish ----
        DONE: begin
          out_p2 <= sat_out(acc_p1);
          vld_p2 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out       = out_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_gauss_interp.sv
// Bench for gauss_interp: directed cases from the datasheet examples plus
// randomized operations checked against an arithmetic reference model.
// Expected results go into a scoreboard queue when an operation starts; a
// monitor pops and compares on every out_valid pulse (value and latency).
`timescale 1ns/1ps

module tb_gauss_interp;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cpu_en = 1'b0;
  logic               start = 1'b0;
  logic signed [14:0] pcm_x [4];
  logic [7:0]         index = 8'd0;
  logic [8:0]         rom_addr;
  logic [10:0]        rom_data = 11'd0;
  logic               busy;
  logic               out_valid;
  logic signed [14:0] out;

  int errors = 0;
  int checks = 0;
  int tick_no = 0;
  int div_cnt = 0;
  bit wrap_en;
  int rom_mode = 0;
  int rom_const = 1024;
  int gtab [512];

  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t sb [$];

  gauss_interp dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_en   (cpu_en),
    .start    (start),
    .pcm_x    (pcm_x),
    .index    (index),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .out_valid(out_valid),
    .out      (out)
  );

  always #5 clk = ~clk;

  // One enabled edge out of every ten.
  initial begin
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt == 9) ? 0 : div_cnt + 1;
      cpu_en  = (div_cnt == 0);
    end
  end

  function automatic int coef(int a);
    return (rom_mode != 0) ? gtab[a] : rom_const;
  endfunction

  // Registered table stub: answers one tick after the address.
  always @(posedge clk) begin
    if (cpu_en) rom_data <= 11'(coef(int'(rom_addr)));
  end

  function automatic int addr_of(int k, int idx);
    case (k)
      0:       return 255 - idx;
      1:       return 511 - idx;
      2:       return 256 + idx;
      default: return idx;
    endcase
  endfunction

  function automatic int model(int x0, int x1, int x2, int x3, int idx);
    int     xs [4];
    longint p;
    longint t;
    int     acc;
    int     m;
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      p = longint'(xs[j]) * longint'(coef(addr_of(j, idx)));
      t = p / 2048;
      if (p < 0 && (p % 2048) != 0) t = t - 1;
      acc = acc + int'(t);
      if (j == 2 && wrap_en) begin
        m = (acc + 16384) % 32768;
        if (m < 0) m = m + 32768;
        acc = m - 16384;
      end
    end
    if (acc > 16383) acc = 16383;
    if (acc < -16384) acc = -16384;
    return acc;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, tick_no);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (!cpu_en);
    #1;
  endtask

  task automatic set_x(int x0, int x1, int x2, int x3);
    pcm_x[0] = 15'(x0);
    pcm_x[1] = 15'(x1);
    pcm_x[2] = 15'(x2);
    pcm_x[3] = 15'(x3);
  endtask

  task automatic scramble();
    for (int j = 0; j < 4; j++) pcm_x[j] = 15'($urandom_range(0, 32767));
    index = 8'($urandom_range(0, 255));
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (cpu_en) begin
        tick_no++;
        #1;
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: out_valid=1 with out=%0d at tick %0d, none pending",
                     out, tick_no);
          end else begin
            e = sb.pop_front();
            check("out_value", int'(out), e.val);
            check("out_latency_tick", tick_no, e.due);
          end
        end
      end
    end
  end

  task automatic run_op(int x0, int x1, int x2, int x3, int idx, int exp, bit repulse);
    int t0;
    exp_t e;
    set_x(x0, x1, x2, x3);
    index = 8'(idx);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = tick_no;
    e.val = exp;
    e.due = t0 + 6;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      check("rom_addr", int'(rom_addr), addr_of(k, idx));
      check("busy_run", int'(busy), 1);
      scramble();
      start = (repulse && k == 2);
      tick();
    end
    start = 1'b0;
    tick();
    check("busy_done", int'(busy), 1);
    tick();
    tick();
    check("valid_one_tick", int'(out_valid), 0);
    check("busy_after", int'(busy), 0);
    check("out_hold", int'(out), exp);
  endtask

  initial begin : stim
    int xv [4];
    int idx;
    int exp;
`ifdef GAUSS_WRAP_EN
    wrap_en = 1'b1;
`else
    wrap_en = 1'b0;
`endif
    for (int j = 0; j < 512; j++) gtab[j] = $urandom_range(0, 2047);
    set_x(0, 0, 0, 0);

    // Reset state.
    #1;
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Address order and basic sum.
    rom_mode = 0;
    rom_const = 1024;
    run_op(100, 200, 300, 400, 8'h10, 500, 1'b0);

    // Floor rounding of a negative half.
    run_op(-1, 0, 0, 0, $urandom_range(0, 255), -1, 1'b0);

    // Third-term wrap versus plain saturation.
    rom_const = 2047;
    run_op(16383, 16383, 0, 0, 8'h40, wrap_en ? -18 : 16383, 1'b0);

    // Start re-pulsed while busy is ignored.
    rom_const = 1024;
    run_op(1000, -2000, 3000, -4000, 8'h22, -1000, 1'b1);
    for (int w = 0; w < 4; w++) tick();

    // Reset mid-operation aborts with no pulse.
    set_x(4000, 4000, 4000, 4000);
    index = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    check("abort_out", int'(out), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_rom_addr", int'(rom_addr), 0);
    tick();
    tick();
    reset = 1'b1;
    for (int w = 0; w < 7; w++) tick();
    check("abort_no_result", int'(out), 0);
    run_op(-100, 50, 700, -3, 8'h7f, 323, 1'b0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      rom_mode  = $urandom_range(0, 1);
      rom_const = $urandom_range(0, 2047);
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 7))
          0:       xv[j] = 16383;
          1:       xv[j] = -16384;
          default: xv[j] = int'($urandom_range(0, 32767)) - 16384;
        endcase
      end
      idx = $urandom_range(0, 255);
      exp = model(xv[0], xv[1], xv[2], xv[3], idx);
      run_op(xv[0], xv[1], xv[2], xv[3], idx, exp, 1'($urandom_range(0, 1)));
      for (int w = $urandom_range(0, 2); w > 0; w--) tick();
    end

    for (int w = 0; w < 20 && sb.size() != 0; w++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results still pending, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
